imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// UART boot loader: receives A5, a word count and little-endian instruction words,
// writes them into instruction memory and holds the core in reset until the load completes.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_SIZE    = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx,
  output logic                         imem_we,
  output logic [$clog2(IMEM_SIZE)-1:0] imem_addr,
  output logic [31:0]                  imem_wdata,
  output logic                         core_hold,
  output logic                         load_done,
  output logic                         load_err
);

  localparam int AW   = $clog2(IMEM_SIZE);
  localparam int CW   = $clog2(IMEM_SIZE + 1);
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]      MAX_N     = 9'(IMEM_SIZE);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_e;
  typedef enum logic [1:0] {P_IDLE, P_COUNT, P_DATA, P_DONE} prot_e;

  uart_e           u_state_q;
  prot_e           p_state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   word_idx_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     word_q;
  logic            fin_q;
  logic            imem_we_q, core_hold_q, load_done_q, load_err_q;
  logic [AW-1:0]   imem_addr_q;
  logic [31:0]     imem_wdata_q;

  logic tick, byte_ok, frame_err, count_ok, last_word;

  assign tick      = (cnt_q == '0);
  assign byte_ok   = (u_state_q == U_STOP) && tick && rx_sync_q;
  assign frame_err = (u_state_q == U_STOP) && tick && !rx_sync_q;
  assign count_ok  = (shift_q != 8'd0) && ({1'b0, shift_q} <= MAX_N);
  assign last_word = ((CW'(word_idx_q) + CW'(1)) == count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      u_state_q    <= U_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      p_state_q    <= P_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      fin_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      imem_we_q  <= 1'b0;
      load_err_q <= 1'b0;
      fin_q      <= 1'b0;

      // Bit timer counts down to zero at each sample point.
      case (u_state_q)
        U_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            u_state_q <= U_START;
            cnt_q     <= HALF_LAST;
          end
        end
        U_START: begin
          if (tick) begin
            if (!rx_sync_q) begin
              u_state_q <= U_DATA;
              cnt_q     <= BIT_LAST;
              bit_idx_q <= '0;
            end else begin
              u_state_q <= U_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        U_DATA: begin
          if (tick) begin
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            cnt_q     <= BIT_LAST;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) u_state_q <= U_STOP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        U_STOP: begin
          if (tick) u_state_q <= U_IDLE;
          else      cnt_q     <= cnt_q - CNTW'(1);
        end
        default: u_state_q <= U_IDLE;
      endcase

      if (frame_err) begin
        load_err_q <= 1'b1;
        p_state_q  <= P_IDLE;
      end else if (byte_ok) begin
        case (p_state_q)
          P_IDLE, P_DONE: begin
            if (shift_q == SYNC_BYTE) begin
              p_state_q   <= P_COUNT;
              core_hold_q <= 1'b1;
              load_done_q <= 1'b0;
            end
          end
          P_COUNT: begin
            if (count_ok) begin
              count_q    <= CW'(shift_q);
              word_idx_q <= '0;
              byte_idx_q <= '0;
              p_state_q  <= P_DATA;
            end else begin
              load_err_q <= 1'b1;
              p_state_q  <= P_IDLE;
            end
          end
          P_DATA: begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= shift_q;
              2'd1: word_q[15:8]  <= shift_q;
              2'd2: word_q[23:16] <= shift_q;
              2'd3: begin
                imem_we_q    <= 1'b1;
                imem_wdata_q <= {shift_q, word_q};
                imem_addr_q  <= word_idx_q;
                word_idx_q   <= word_idx_q + AW'(1);
                if (last_word) begin
                  p_state_q <= P_DONE;
                  fin_q     <= 1'b1;
                end
              end
            endcase
          end
          default: p_state_q <= P_IDLE;
        endcase
      end

      // Completion becomes visible the cycle after the final write strobe.
      if (fin_q) begin
        load_done_q <= 1'b1;
        core_hold_q <= 1'b0;
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
